// File: rtl/common_types_pkg.sv
// Shared types for the forwarding/scoreboard slice: register index, forward-select codes.
// Optional stall cycle counter is enabled with FWD_STALL_COUNT_EN.
package common_types_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int FWD_SEL_W = 2;

  typedef logic [REG_IDX_W-1:0] reg_t;

  // Code 0 reads the register file, code k takes the value from forwarding stage k-1.
  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/forward_scoreboard_if.sv
// Bundles the forward_scoreboard signals for the design and its bench.
// stall_cycles exists only when FWD_STALL_COUNT_EN is defined.
interface forward_scoreboard_if
  import common_types_pkg::*;
#(
  parameter int NUM_RD_PORTS   = 2,
  parameter int NUM_FWD_STAGES = 2
) (
  input logic CLK
);

  logic                                  nRST;
  reg_t [NUM_RD_PORTS-1:0]               ex_rsel;
  logic [NUM_RD_PORTS-1:0]               ex_ren;
  reg_t [NUM_FWD_STAGES-1:0]             stage_rd;
  logic [NUM_FWD_STAGES-1:0]             stage_wen;
  logic [NUM_FWD_STAGES-1:0]             stage_rdy;
  logic                                  issue_valid;
  reg_t                                  issue_rd;
  logic                                  done_valid;
  reg_t                                  done_rd;
  logic                                  flush;
  logic [NUM_RD_PORTS-1:0][FWD_SEL_W-1:0] fwd_sel;
  logic                                  stall;
  logic                                  busy;
`ifdef FWD_STALL_COUNT_EN
  logic [31:0]                           stall_cycles;
`endif

  modport forward_scoreboard (
    input  CLK, nRST, ex_rsel, ex_ren, stage_rd, stage_wen, stage_rdy,
    input  issue_valid, issue_rd, done_valid, done_rd, flush,
`ifdef FWD_STALL_COUNT_EN
    output stall_cycles,
`endif
    output fwd_sel, stall, busy
  );

  modport tb (
    input  CLK, fwd_sel, stall, busy,
`ifdef FWD_STALL_COUNT_EN
    input  stall_cycles,
`endif
    output nRST, ex_rsel, ex_ren, stage_rd, stage_wen, stage_rdy,
    output issue_valid, issue_rd, done_valid, done_rd, flush
  );

endinterface

// File: rtl/fwd_scoreboard_table.sv
// Pending-register table and outstanding-op counter for long-latency results.
// A clear on a register that is not pending is ignored; the counter never wraps.
module fwd_scoreboard_table
  import common_types_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                set_valid,
  input  reg_t                set_rd,
  input  logic                clr_valid,
  input  reg_t                clr_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    outstanding,
  output logic                busy
);

  logic [NUM_REGS-1:0] pending_next;
  logic [CNT_W-1:0]    count_next;
  logic                set_hit;
  logic                clr_hit;

  // Clear is applied before set so an issue and done to the same register leave it pending.
  always_comb begin
    set_hit      = set_valid && (set_rd != '0);
    clr_hit      = clr_valid && pending[clr_rd];
    pending_next = pending;
    count_next   = outstanding;
    if (clr_hit) begin
      pending_next[clr_rd] = 1'b0;
    end
    if (set_hit) begin
      pending_next[set_rd] = 1'b1;
    end
    if (set_hit && !clr_hit && (outstanding != CNT_W'(MAX_OUTSTANDING))) begin
      count_next = outstanding + 1'b1;
    end else if (clr_hit && !set_hit && (outstanding != '0)) begin
      count_next = outstanding - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending     <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
    end else begin
      pending     <= pending_next;
      outstanding <= count_next;
      busy        <= (count_next != '0);
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// EX-stage operand forwarding select and hazard stall generation over a long-latency scoreboard.
// Define FWD_STALL_COUNT_EN to add the saturating stall_cycles counter output.
module forward_scoreboard
  import common_types_pkg::*;
#(
  parameter int NUM_RD_PORTS    = 2,
  parameter int NUM_FWD_STAGES  = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  reg_t [NUM_RD_PORTS-1:0]                ex_rsel,
  input  logic [NUM_RD_PORTS-1:0]                ex_ren,
  input  reg_t [NUM_FWD_STAGES-1:0]              stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]              stage_wen,
  input  logic [NUM_FWD_STAGES-1:0]              stage_rdy,
  input  logic                                   issue_valid,
  input  reg_t                                   issue_rd,
  input  logic                                   done_valid,
  input  reg_t                                   done_rd,
  input  logic                                   flush,
  output logic [NUM_RD_PORTS-1:0][FWD_SEL_W-1:0] fwd_sel,
  output logic                                   stall,
`ifdef FWD_STALL_COUNT_EN
  output logic [31:0]                            stall_cycles,
`endif
  output logic                                   busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0]     pending;
  logic [CNT_W-1:0]        outstanding;
  logic [NUM_RD_PORTS-1:0] port_used;
  logic [NUM_RD_PORTS-1:0] port_hit;
  logic [NUM_RD_PORTS-1:0] port_hit_rdy;
  logic [NUM_RD_PORTS-1:0] port_stall;
  logic                    issue_stall;
  logic                    issue_accept;

  // Stages are scanned oldest first so the youngest matching stage wins.
  always_comb begin
    port_used    = '0;
    port_hit     = '0;
    port_hit_rdy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      fwd_sel[p] = FWD_RF;
      if (ex_ren[p] && (ex_rsel[p] != '0)) begin
        port_used[p] = 1'b1;
        for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
          if (stage_wen[s] && (stage_rd[s] == ex_rsel[p])) begin
            fwd_sel[p]      = FWD_SEL_W'(s + 1);
            port_hit[p]     = 1'b1;
            port_hit_rdy[p] = stage_rdy[s];
          end
        end
      end
    end
  end

  // A pending source is satisfied by a ready forwarding stage or by a same-cycle done write.
  always_comb begin
    port_stall = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (port_used[p]) begin
        if (port_hit[p] && !port_hit_rdy[p]) begin
          port_stall[p] = 1'b1;
        end else if (pending[ex_rsel[p]] && !port_hit[p] &&
                     !(done_valid && (done_rd == ex_rsel[p]))) begin
          port_stall[p] = 1'b1;
        end
      end
    end
    issue_stall  = issue_valid &&
                   (((issue_rd != '0) && pending[issue_rd]) ||
                    (outstanding == CNT_W'(MAX_OUTSTANDING)));
    stall        = (|port_stall) || issue_stall;
    issue_accept = issue_valid && !stall && !flush && (issue_rd != '0);
  end

  fwd_scoreboard_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_table (
    .CLK         (CLK),
    .nRST        (nRST),
    .set_valid   (issue_accept),
    .set_rd      (issue_rd),
    .clr_valid   (done_valid),
    .clr_rd      (done_rd),
    .pending     (pending),
    .outstanding (outstanding),
    .busy        (busy)
  );

`ifdef FWD_STALL_COUNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: forwarding priority, load-use, scoreboard and reset.
// Stall counter port is connected only when FWD_STALL_COUNT_EN is defined.
module tb_forward_scoreboard;
  import common_types_pkg::*;

  logic                   CLK;
  logic                   nRST;
  reg_t [1:0]             ex_rsel;
  logic [1:0]             ex_ren;
  reg_t [1:0]             stage_rd;
  logic [1:0]             stage_wen;
  logic [1:0]             stage_rdy;
  logic                   issue_valid;
  reg_t                   issue_rd;
  logic                   done_valid;
  reg_t                   done_rd;
  logic                   flush;
  logic [1:0][FWD_SEL_W-1:0] fwd_sel;
  logic                   stall;
  logic                   busy;
`ifdef FWD_STALL_COUNT_EN
  logic [31:0]            stall_cycles;
`endif

  int checks = 0;
  int passed = 0;

  forward_scoreboard #(
    .NUM_RD_PORTS    (2),
    .NUM_FWD_STAGES  (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ex_rsel      (ex_rsel),
    .ex_ren       (ex_ren),
    .stage_rd     (stage_rd),
    .stage_wen    (stage_wen),
    .stage_rdy    (stage_rdy),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .done_valid   (done_valid),
    .done_rd      (done_rd),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
`ifdef FWD_STALL_COUNT_EN
    .stall_cycles (stall_cycles),
`endif
    .busy         (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic applyStimulus();
    ex_rsel     = '0;
    ex_ren      = '0;
    stage_rd    = '0;
    stage_wen   = '0;
    stage_rdy   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    done_valid  = 1'b0;
    done_rd     = '0;
    flush       = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    applyStimulus();
    nRST = 1'b0;
    #2;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_stall", 32'(stall), 0);
    checkOutput("reset_fwd0", 32'(fwd_sel[0]), 0);
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // MEM and WB both write r5: youngest (MEM) wins; unused port stays on the register file
    ex_rsel[0] = 5'd5; ex_ren = 2'b01; ex_rsel[1] = 5'd5;
    stage_rd[0] = 5'd5; stage_wen[0] = 1'b1; stage_rdy[0] = 1'b1;
    stage_rd[1] = 5'd5; stage_wen[1] = 1'b1; stage_rdy[1] = 1'b1;
    #1;
    checkOutput("mem_priority_sel", 32'(fwd_sel[0]), 1);
    checkOutput("mem_priority_stall", 32'(stall), 0);
    checkOutput("unused_port_sel", 32'(fwd_sel[1]), 0);
    stage_wen[0] = 1'b0;
    #1;
    checkOutput("wb_only_sel", 32'(fwd_sel[0]), 2);

    // load-use on port 1, resolved from WB the following cycle
    applyStimulus();
    ex_rsel[1] = 5'd7; ex_ren = 2'b10;
    stage_rd[0] = 5'd7; stage_wen[0] = 1'b1; stage_rdy[0] = 1'b0;
    #1;
    checkOutput("load_use_stall", 32'(stall), 1);
    checkOutput("load_use_sel", 32'(fwd_sel[1]), 1);
    tick();
    stage_wen[0] = 1'b0;
    stage_rd[1] = 5'd7; stage_wen[1] = 1'b1; stage_rdy[1] = 1'b1;
    #1;
    checkOutput("load_wb_sel", 32'(fwd_sel[1]), 2);
    checkOutput("load_wb_stall", 32'(stall), 0);

    // x0 is never forwarded and never tracked
    applyStimulus();
    ex_rsel[0] = 5'd0; ex_ren = 2'b01;
    stage_rd[0] = 5'd0; stage_wen[0] = 1'b1; stage_rdy[0] = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checkOutput("x0_sel", 32'(fwd_sel[0]), 0);
    checkOutput("x0_stall", 32'(stall), 0);
    tick();
    applyStimulus();
    #1;
    checkOutput("x0_issue_busy", 32'(busy), 0);

    // r9 pending: consumer stalls until the done cycle, which bypasses through the register file
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    applyStimulus();
    ex_rsel[0] = 5'd9; ex_ren = 2'b01;
    #1;
    checkOutput("r9_busy", 32'(busy), 1);
    checkOutput("r9_pending_stall", 32'(stall), 1);
    tick();
    checkOutput("r9_still_stall", 32'(stall), 1);
    done_valid = 1'b1; done_rd = 5'd9;
    #1;
    checkOutput("r9_done_bypass", 32'(stall), 0);
    tick();
    done_valid = 1'b0;
    #1;
    checkOutput("r9_done_busy", 32'(busy), 0);
    checkOutput("r9_cleared_stall", 32'(stall), 0);

    // flush suppresses a same-cycle issue
    applyStimulus();
    issue_valid = 1'b1; issue_rd = 5'd10; flush = 1'b1;
    tick();
    applyStimulus();
    #1;
    checkOutput("flush_busy", 32'(busy), 0);

    // fill to capacity with r1..r4
    for (int r = 1; r <= 4; r++) begin
      issue_valid = 1'b1; issue_rd = reg_t'(r);
      #1;
      checkOutput("fill_stall", 32'(stall), 0);
      tick();
    end
    issue_rd = 5'd6;
    #1;
    checkOutput("full_busy", 32'(busy), 1);
    checkOutput("full_stall", 32'(stall), 1);
    done_valid = 1'b1; done_rd = 5'd2;
    #1;
    checkOutput("full_done_stall", 32'(stall), 1);
    tick();
    done_valid = 1'b0;
    #1;
    checkOutput("after_done_stall", 32'(stall), 0);
    tick();
    issue_valid = 1'b0;

    // pending r6 relieved only by a ready forwarding stage
    ex_rsel[0] = 5'd6; ex_ren = 2'b01;
    #1;
    checkOutput("r6_pending_stall", 32'(stall), 1);
    stage_rd[1] = 5'd6; stage_wen[1] = 1'b1; stage_rdy[1] = 1'b1;
    #1;
    checkOutput("r6_wb_sel", 32'(fwd_sel[0]), 2);
    checkOutput("r6_wb_stall", 32'(stall), 0);
    stage_rd[0] = 5'd6; stage_wen[0] = 1'b1; stage_rdy[0] = 1'b0;
    #1;
    checkOutput("r6_mem_load_sel", 32'(fwd_sel[0]), 1);
    checkOutput("r6_mem_load_stall", 32'(stall), 1);
    applyStimulus();

    // done r1 frees a slot; done r2 (no longer pending) must not free another
    done_valid = 1'b1; done_rd = 5'd1;
    tick();
    done_rd = 5'd2;
    tick();
    done_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checkOutput("r7_issue_stall", 32'(stall), 0);
    tick();
    issue_rd = 5'd8;
    #1;
    checkOutput("ignored_done_full", 32'(stall), 1);
    issue_valid = 1'b0;
    done_valid = 1'b1; done_rd = 5'd7;
    tick();
    done_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    checkOutput("waw_stall", 32'(stall), 1);
    issue_valid = 1'b0;

    // mid-cycle reset with r3, r4, r6 outstanding
    #2;
    nRST = 1'b0;
    ex_rsel[0] = 5'd3; ex_ren = 2'b01;
    #1;
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_stall", 32'(stall), 0);
    nRST = 1'b1;
    tick();
    ex_ren = 2'b00;
    done_valid = 1'b1; done_rd = 5'd1;
    tick();
    done_valid = 1'b0;
    #1;
    checkOutput("post_reset_done_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
